mem_copy_sequencer: RTL and testbench



---
 rtl/mem_copy_sequencer.sv | 131 +++++++++++++
 tb/tb_mem_copy_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_copy_sequencer.sv
// Word-by-word copy engine: reads mem0 at one word per cycle and writes each word
// to mem1 one cycle later through a single-stage pipeline.
module mem_copy_sequencer #(
   parameter int AWIDTH = 10,
   parameter int DWIDTH = 32,
   parameter int SWIDTH = 4
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              start,
   input  logic              abort,
   input  logic [AWIDTH-1:0] src_addr,
   input  logic [AWIDTH-1:0] dst_addr,
   input  logic [AWIDTH:0]   len,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [AWIDTH:0]   xfer_cnt,
   output logic              mem0_en,
   output logic [SWIDTH-1:0] mem0_we,
   output logic [AWIDTH-1:0] mem0_addr,
   output logic [DWIDTH-1:0] mem0_wdata,
   input  logic [DWIDTH-1:0] mem0_rdata,
   output logic              mem1_en,
   output logic [SWIDTH-1:0] mem1_we,
   output logic [AWIDTH-1:0] mem1_addr,
   output logic [DWIDTH-1:0] mem1_wdata,
   input  logic [DWIDTH-1:0] mem1_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_COPY, S_DRAIN, S_DONE} state_t;

   localparam logic [AWIDTH:0] CNT_ONE = 1;

   state_t            state_q, state_d;
   logic [AWIDTH-1:0] src_q, src_d, dst_q, dst_d;
   logic [AWIDTH:0]   len_q, len_d, rd_cnt_q, rd_cnt_d, xfer_cnt_q, xfer_cnt_d;
   logic              aborted_q, aborted_d, rd_vld_q, rd_vld_d;
   logic              rd_issue, last_rd;
   logic              unused_mem1_rdata;

   assign unused_mem1_rdata = ^mem1_rdata;

   // Abort suppresses the read of the very cycle it is seen in, so it gates the enable directly.
   assign rd_issue = (state_q == S_COPY) && !abort;
   assign last_rd  = (rd_cnt_q == (len_q - CNT_ONE));

   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      dst_d      = dst_q;
      len_d      = len_q;
      rd_cnt_d   = rd_cnt_q;
      xfer_cnt_d = xfer_cnt_q;
      aborted_d  = aborted_q;
      rd_vld_d   = rd_issue;
      if (rd_vld_q) begin
         xfer_cnt_d = xfer_cnt_q + CNT_ONE;
      end
      case (state_q)
         S_IDLE: begin
            if (start) begin
               rd_cnt_d   = '0;
               xfer_cnt_d = '0;
               aborted_d  = 1'b0;
               if (len != '0) begin
                  src_d   = src_addr;
                  dst_d   = dst_addr;
                  len_d   = len;
                  state_d = S_COPY;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_COPY: begin
            if (rd_issue) begin
               rd_cnt_d = rd_cnt_q + CNT_ONE;
            end
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = S_DRAIN;
            end else if (last_rd) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q    <= S_IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         len_q      <= '0;
         rd_cnt_q   <= '0;
         xfer_cnt_q <= '0;
         aborted_q  <= 1'b0;
         rd_vld_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         len_q      <= len_d;
         rd_cnt_q   <= rd_cnt_d;
         xfer_cnt_q <= xfer_cnt_d;
         aborted_q  <= aborted_d;
         rd_vld_q   <= rd_vld_d;
      end
   end

   assign busy     = (state_q == S_COPY) || (state_q == S_DRAIN);
   assign done     = (state_q == S_DONE);
   assign aborted  = aborted_q;
   assign xfer_cnt = xfer_cnt_q;

   // Every SRAM output is forced to zero when no access is being made.
   assign mem0_en    = rd_issue;
   assign mem0_we    = '0;
   assign mem0_addr  = rd_issue ? (src_q + rd_cnt_q[AWIDTH-1:0]) : '0;
   assign mem0_wdata = '0;

   assign mem1_en    = rd_vld_q;
   assign mem1_we    = {SWIDTH{rd_vld_q}};
   assign mem1_addr  = rd_vld_q ? (dst_q + xfer_cnt_q[AWIDTH-1:0]) : '0;
   assign mem1_wdata = rd_vld_q ? mem0_rdata : '0;

endmodule

// File: tb/tb_mem_copy_sequencer.sv
// Bench for mem_copy_sequencer: SRAM model on mem0, expected mem1 writes queued per request.
module tb_mem_copy_sequencer;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int W  = AW + DW;

   logic          CLK = 1'b0;
   logic          RSTN;
   logic          start, abort;
   logic [AW-1:0] src_addr, dst_addr;
   logic [AW:0]   len;
   logic          busy, done, aborted;
   logic [AW:0]   xfer_cnt;
   logic          mem0_en, mem1_en;
   logic [SW-1:0] mem0_we, mem1_we;
   logic [AW-1:0] mem0_addr, mem1_addr;
   logic [DW-1:0] mem0_wdata, mem0_rdata, mem1_wdata, mem1_rdata;

   logic [DW-1:0] mem0 [0:(1<<AW)-1];
   logic [W-1:0]  exp_q [$];

   int n_checks = 0;
   int n_errors = 0;
   int rd_count = 0;
   int wr_count = 0;
   int done_cnt = 0;

   mem_copy_sequencer #(.AWIDTH(AW), .DWIDTH(DW), .SWIDTH(SW)) dut (
      .CLK(CLK), .RSTN(RSTN), .start(start), .abort(abort),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
      .busy(busy), .done(done), .aborted(aborted), .xfer_cnt(xfer_cnt),
      .mem0_en(mem0_en), .mem0_we(mem0_we), .mem0_addr(mem0_addr),
      .mem0_wdata(mem0_wdata), .mem0_rdata(mem0_rdata),
      .mem1_en(mem1_en), .mem1_we(mem1_we), .mem1_addr(mem1_addr),
      .mem1_wdata(mem1_wdata), .mem1_rdata(mem1_rdata)
   );

   always #5 CLK = ~CLK;

   assign mem1_rdata = '0;

   always @(posedge CLK) begin
      if (mem0_en) mem0_rdata <= mem0[mem0_addr];
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Monitor: counts accesses and pops one expected write per observed mem1 write.
   always @(negedge CLK) begin
      if (mem0_en) rd_count++;
      else check("mem0_idle", 64'(mem0_addr), 64'd0);
      check("mem0_wr", 64'({mem0_we, mem0_wdata}), 64'd0);
      if (mem1_en) begin
         wr_count++;
         check("mem1_we", 64'(mem1_we), 64'hF);
         if (exp_q.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
         else check("wr_data", 64'({mem1_addr, mem1_wdata}), 64'(exp_q.pop_front()));
      end else begin
         check("mem1_idle", 64'({mem1_we, mem1_addr, mem1_wdata}), 64'd0);
      end
      if (done) done_cnt++;
   end

   // ab_cyc: COPY-cycle index (1-based) in which abort is held high; 0 for none.
   // ghost: pulse start again while busy and in the done cycle.
   task automatic run_copy(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                           input logic [AW:0] n, input int ab_cyc, input bit ghost);
      int n_exp, exp_done, done_at, busy_seen, rd0, wr0, d0;
      bit ab_hit;
      logic [AW-1:0] a, d;
      ab_hit   = (ab_cyc >= 1) && (ab_cyc <= int'(n));
      n_exp    = ab_hit ? ab_cyc - 1 : int'(n);
      exp_done = (n == 0) ? 1 : (ab_hit ? ab_cyc + 2 : int'(n) + 2);
      for (int i = 0; i < n_exp; i++) begin
         a = src + AW'(i);
         d = dst + AW'(i);
         exp_q.push_back({d, mem0[a]});
      end
      rd0 = rd_count;
      wr0 = wr_count;
      d0  = done_cnt;
      @(posedge CLK); #1;
      start = 1'b1; src_addr = src; dst_addr = dst; len = n;
      @(posedge CLK); #1;
      start = 1'b0; src_addr = ~src; dst_addr = ~dst; len = n ^ 11'h7;
      busy_seen = 0;
      done_at   = 0;
      for (int i = 1; i <= exp_done + 4; i++) begin
         abort = (ab_cyc != 0) && (i == ab_cyc);
         start = ghost && ((i == 2) || (i == exp_done));
         @(negedge CLK);
         if (busy) busy_seen++;
         if (done) begin
            done_at = i;
            check("xfer_cnt", 64'(xfer_cnt), 64'(n_exp));
            check("aborted", 64'(aborted), 64'(ab_hit));
            break;
         end
         @(posedge CLK); #1;
      end
      check("done_cycle", 64'(done_at), 64'(exp_done));
      check("busy_cycles", 64'(busy_seen), 64'(exp_done - 1));
      @(posedge CLK); #1;
      start = 1'b0;
      abort = 1'b0;
      repeat (3) @(negedge CLK);
      check("post_busy", 64'({busy, done}), 64'd0);
      check("reads", 64'(rd_count - rd0), 64'(n_exp));
      check("writes", 64'(wr_count - wr0), 64'(n_exp));
      check("done_pulses", 64'(done_cnt - d0), 64'd1);
      check("sb_empty", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   task automatic reset_mid_copy();
      int rd0, wr0, d0;
      exp_q.push_back({10'h300, mem0[10'h100]});
      rd0 = rd_count;
      wr0 = wr_count;
      d0  = done_cnt;
      @(posedge CLK); #1;
      start = 1'b1; src_addr = 10'h100; dst_addr = 10'h300; len = 11'd16;
      @(posedge CLK); #1;
      start = 1'b0;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RSTN = 1'b0;
      #1;
      check("rst_async", 64'({busy, done, aborted, xfer_cnt, mem0_en, mem0_addr, mem1_en, mem1_addr}),
            64'd0);
      repeat (3) @(negedge CLK);
      check("rst_hold", 64'({busy, xfer_cnt, mem1_en}), 64'd0);
      @(posedge CLK); #1;
      RSTN = 1'b1;
      check("rst_reads", 64'(rd_count - rd0), 64'd2);
      check("rst_writes", 64'(wr_count - wr0), 64'd1);
      check("rst_no_done", 64'(done_cnt - d0), 64'd0);
      check("rst_sb_empty", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      RSTN = 1'b0; start = 1'b0; abort = 1'b0;
      src_addr = '0; dst_addr = '0; len = '0;
      for (int i = 0; i < (1 << AW); i++) mem0[i] = $urandom;
      for (int i = 0; i < 4; i++) mem0[10'h010 + i] = 32'hA000_0000 + DW'(i);
      repeat (3) @(negedge CLK);
      check("reset_state", 64'({busy, done, aborted, xfer_cnt, mem0_en, mem1_en}), 64'd0);
      @(posedge CLK); #1;
      RSTN = 1'b1;

      run_copy(10'h010, 10'h200, 11'd4, 0, 1'b0);
      run_copy(10'h005, 10'h105, 11'd0, 0, 1'b0);
      run_copy(10'h3FE, 10'h3FF, 11'd3, 0, 1'b0);
      run_copy(10'h040, 10'h140, 11'd8, 4, 1'b0);
      run_copy(10'h050, 10'h150, 11'd4, 4, 1'b0);
      run_copy(10'h060, 10'h160, 11'd5, 1, 1'b0);
      run_copy(10'h070, 10'h170, 11'd3, 4, 1'b0);
      run_copy(10'h080, 10'h180, 11'd6, 0, 1'b1);
      run_copy(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
               11'($urandom_range(1, 20)), 0, 1'b0);
      run_copy(10'h155, 10'h2AA, 11'h400, 0, 1'b0);
      reset_mid_copy();
      run_copy(10'h020, 10'h220, 11'd5, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
